// File: rtl/seg_pkg.sv
// seg_pkg: shared segment table, blank pattern and parameter legal-range limits
package seg_pkg;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 8;
  localparam int MIN_CLK_DIV = 2;
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: hex nibble to active-high g..a segment pattern
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with tear-free frame updates
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 0,
  parameter int SEG_ACT_LOW = 0,
  parameter int SEL_ACT_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [7:0]              seg_led,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic                    frame_done
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] LED_INV = SEG_ACT_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_INV = SEL_ACT_LOW != 0 ? '1 : '0;
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic pend;
  logic [4*NUM_DIGITS-1:0] data_pend, data_act;
  logic [NUM_DIGITS-1:0] dp_pend, dp_act, en_pend, en_act, blank;
  logic tick, wrap, zero_above;
  logic [6:0] seg7;
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
  seg_hex_decoder u_dec (.nib(data_act[{idx, 2'b00} +: 4]), .seg(seg7));
  // Scan from the top digit down so a digit knows whether every enabled digit above it is zero
  always_comb begin
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (~en_act[k] | (data_act[4*k +: 4] == 4'h0));
      blank[k] = ~en_act[k] | (lz_en & (k != 0) & zero_above);
    end
  end
  // Prescaler, digit index and shadow/active registers; active set only changes on frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx <= '0;
      pend <= 1'b0;
      data_pend <= '0;
      dp_pend <= '0;
      en_pend <= '0;
      data_act <= '0;
      dp_act <= '0;
      en_act <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      idx <= wrap ? '0 : tick ? idx + 1'b1 : idx;
      if (wrap && load) begin
        data_act <= data_in;
        dp_act <= dp_in;
        en_act <= digit_en;
        pend <= 1'b0;
      end else if (wrap && pend) begin
        data_act <= data_pend;
        dp_act <= dp_pend;
        en_act <= en_pend;
        pend <= 1'b0;
      end else if (load) begin
        data_pend <= data_in;
        dp_pend <= dp_in;
        en_pend <= digit_en;
        pend <= 1'b1;
      end
    end
  end
  // Output registers; pin polarity is applied only here
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_led <= SEG_OFF ^ LED_INV;
      seg_sel <= SEL_INV;
      frame_done <= 1'b0;
    end else begin
      seg_led <= (blank[idx] ? SEG_OFF : {dp_act[idx], seg7}) ^ LED_INV;
      seg_sel <= ((32'(div_cnt) < BLANK_CYC) ? '0 : NUM_DIGITS'(1) << idx) ^ SEL_INV;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench against a time-based reference model
module tb_seg_scan_driver;
  localparam int N = 4, CD = 4, BC = 1;
  logic clk = 0, rst = 0, load = 0, lz_en = 0;
  logic [15:0] data_in = 0;
  logic [3:0] dp_in = 0, digit_en = 0, seg_sel;
  logic [7:0] seg_led;
  logic frame_done;
  typedef struct {logic [7:0] led; logic [3:0] sel; logic fd;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, t = 0;
  logic [15:0] a_data = 0, p_data = 0;
  logic [3:0] a_dp = 0, a_en = 0, p_dp = 0, p_en = 0;
  bit pend = 0;
  logic [6:0] segt [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC), .SEG_ACT_LOW(0), .SEL_ACT_LOW(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .lz_en(lz_en), .seg_led(seg_led), .seg_sel(seg_sel), .frame_done(frame_done));

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_led(int s);
    bit z = 1;
    for (int j = N - 1; j >= s; j--) if (a_en[j] && a_data[4*j +: 4] != 0) z = 0;
    if (!a_en[s] || (lz_en && s > 0 && z)) return 8'h00;
    return {a_dp[s], segt[a_data[4*s +: 4]]};
  endfunction

  task automatic cyc(input bit r, input bit ld);
    int ph, sl;
    exp_t e;
    rst = r;
    load = ld;
    ph = t % CD;
    sl = (t / CD) % N;
    if (r) begin
      e = '{8'h00, 4'hF, 1'b0};
      t = 0; pend = 0;
      a_data = 0; a_dp = 0; a_en = 0;
    end else begin
      e.fd = ph == CD - 1 && sl == N - 1;
      e.sel = ph < BC ? 4'hF : ~(4'b0001 << sl);
      e.led = exp_led(sl);
      if (e.fd) begin
        if (ld) begin a_data = data_in; a_dp = dp_in; a_en = digit_en; end
        else if (pend) begin a_data = p_data; a_dp = p_dp; a_en = p_en; end
        pend = 0;
      end else if (ld) begin
        p_data = data_in; p_dp = dp_in; p_en = digit_en; pend = 1;
      end
      t++;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    load = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  task automatic go_to(input int ph, input int sl);
    for (int i = 0; i < 2 * CD * N && !(t % CD == ph && (t / CD) % N == sl); i++) cyc(0, 0);
  endtask

  task automatic ld(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    data_in = d; dp_in = p; digit_en = e;
    cyc(0, 1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (seg_led !== e.led || seg_sel !== e.sel || frame_done !== e.fd) begin
        errors++;
        $display("FAIL out @%0t: led=%h want %h, sel=%h want %h, frame_done=%b want %b",
                 $time, seg_led, e.led, seg_sel, e.sel, frame_done, e.fd);
      end
    end
  end

  initial begin
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    run(5);
    ld(16'h12AF, 4'h0, 4'hF);
    run(3 * CD * N);
    lz_en = 1;
    ld(16'h0050, 4'h0, 4'hF);
    run(2 * CD * N);
    ld(16'h0000, 4'h0, 4'hF);
    run(2 * CD * N);
    lz_en = 0;
    go_to(0, 1);
    ld(16'h1111, 4'h0, 4'hF);
    run(3);
    ld(16'h2222, 4'h0, 4'hF);
    run(2 * CD * N);
    go_to(CD - 1, N - 1);
    ld(16'h3333, 4'h0, 4'hF);
    run(2 * CD * N);
    ld(16'h9876, 4'b0100, 4'b1011);
    run(2 * CD * N);
    lz_en = 1;
    ld(16'h0304, 4'b1111, 4'b0111);
    run(2 * CD * N);
    lz_en = 0;
    go_to(2, 2);
    cyc(1, 0);
    run(2 * CD * N);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) lz_en = ~lz_en;
      if ($urandom_range(399) == 0) cyc(1, 0);
      else if ($urandom_range(11) == 0) begin
        data_in = 16'($urandom);
        if ($urandom_range(2) == 0) data_in = data_in & 16'h00FF;
        dp_in = 4'($urandom);
        digit_en = 4'($urandom);
        cyc(0, 1);
      end else cyc(0, 0);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits (legal range 1..8).
REQ-002 Parameter CLK_DIV, default 50000: clock cycles per digit slot (legal range >= 2).
REQ-003 Parameter BLANK_CYC, default 0: anti-ghost cycles at the start of each slot (legal range 0..CLK_DIV-1).
REQ-004 Parameter SEG_ACT_LOW, default 0: 1 inverts all seg_led bits at the pins.
REQ-005 Parameter SEL_ACT_LOW, default 1: 1 means the selected digit line drives 0.
REQ-006 clk  input  1  single clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 data_in  input  4*NUM_DIGITS  hex nibble per digit; nibble k drives digit k, and digit 0 is the rightmost.
REQ-009 dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-010 digit_en  input  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-011 load  input  1  one-cycle strobe that captures data_in, dp_in and digit_en.
REQ-012 lz_en  input  1  level; 1 enables leading-zero suppression.
REQ-013 seg_led  output  8  segments {dp,g,f,e,d,c,b,a}, registered.
REQ-014 seg_sel  output  NUM_DIGITS  one-hot digit select, registered.
REQ-015 frame_done  output  1  one-cycle pulse when a full scan of all digits completes.

Function
REQ-016 Prescaler div_cnt SHALL count 0..CLK_DIV-1 and wrap; the cycle with div_cnt==CLK_DIV-1 is "tick".
REQ-017 Digit index idx SHALL advance on tick, with wrap NUM_DIGITS-1 -> 0; that wrap is "frame wrap".
REQ-018 frame_done SHALL be high exactly on the cycle after a frame wrap tick, for one cycle.
REQ-019 load SHALL copy data_in, dp_in and digit_en into the pending registers and set pend; a later load before application SHALL overwrite them (last load wins).
REQ-020 On frame wrap with pend=1, the active registers SHALL take the pending values and pend SHALL clear.
REQ-021 If load and frame wrap coincide, data_in, dp_in and digit_en SHALL go directly to the active registers, and pend SHALL clear.
REQ-022 Active registers SHALL never change mid-frame (no tearing).
REQ-023 Hex-to-segment map for g..a, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-024 Segment bit 7 SHALL equal the active dp bit of the selected digit.
REQ-025 With lz_en=1, digit k (k>=1) SHALL be blanked when its nibble and every nibble above it among enabled digits are 0.
REQ-026 Digit 0 SHALL never be suppressed; a dp on a suppressed digit SHALL also be blanked.
REQ-027 A blanked digit (digit_en=0 or suppressed) SHALL drive all segments inactive while seg_sel still selects it.
REQ-028 While div_cnt < BLANK_CYC, seg_sel SHALL be all-inactive.
REQ-029 seg_led and seg_sel SHALL reflect the idx and div_cnt state with exactly 1 cycle of latency.
REQ-030 Polarity (SEG_ACT_LOW, SEL_ACT_LOW) SHALL be applied at the output registers only.

Reset
REQ-031 On rst=1 at a clock edge: div_cnt=0, idx=0, pend=0, active/pending data=0, active dp=0, active digit_en=0.
REQ-032 On reset, outputs SHALL be: frame_done=0, seg_sel all-inactive, seg_led all-inactive (0x00, or 0xFF if SEG_ACT_LOW).
REQ-033 Reset asserted mid-frame SHALL discard pending data, and scanning SHALL restart from digit 0 on the first cycle after rst deasserts.

Structure
REQ-034 The shared package seg_pkg SHALL hold the 16-entry segment table constants, SEG_OFF and the parameter legal-range limits.
REQ-035 Sub-module seg_hex_decoder: combinational, 4-bit nibble -> 7-bit g..a per REQ-023, instantiated once on the selected nibble.
REQ-036 Prescaler, scan index, shadow/active registers, suppression and output registers SHALL reside in seg_scan_driver.

Verification (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, SEG_ACT_LOW=0, SEL_ACT_LOW=1)
REQ-037 Reset then load data_in=16'h12AF, dp_in=0, digit_en=F -> after the next frame_done: slot 0 gives seg_led=71, slot 1 gives 77, slot 2 gives 5B, slot 3 gives 06; seg_sel = E, D, B, 7 respectively, and 4'hF in the first cycle of each slot.
REQ-038 lz_en=1 with data_in=16'h0050 and digit_en=F -> digits 3 and 2 blank (seg_led=00), digit 1 = 6D, digit 0 = 3F; data_in=16'h0000 -> only digit 0 shows 3F.
REQ-039 Load 16'h1111 mid-frame, then 16'h2222 before wrap -> the current frame keeps the old values; the next frame shows 5B on all digits and never 06.
REQ-040 load asserted on the frame-wrap tick with 16'h3333 -> the first slot of the new frame shows 4F, and pend=0 afterwards.
REQ-041 dp_in=4'b0100 with digit_en=4'b1011 -> digit 2 shows seg_led=00 (dp blanked), and the other digits have bit 7 = 0.
REQ-042 rst pulsed during slot 2 -> the next cycle gives seg_sel=F, seg_led=00, frame_done=0; scanning then restarts at digit 0 showing blank until a new load.
